lc3_display_uart: RTL and testbench
===================================

LC3_DISPLAY_UART -- requirements
Module: lc3_display_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, giving i_CLK cycles per UART bit (217 gives 115200 baud at 25 MHz).
REQ-002 SHALL have parameter DSR_ADDR, default 16'hFE04, giving the display status register address.
REQ-003 SHALL have parameter DDR_ADDR, default 16'hFE06, giving the display data register address.
REQ-004 SHALL have port i_CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_Addr, input, 16 bits: memory-mapped I/O address from the LC3 memory controller.
REQ-007 SHALL have port i_Wr_En, input, 1 bit: one-cycle write strobe qualifying i_Addr and i_Wr_Data.
REQ-008 SHALL have port i_Wr_Data, input, 16 bits: write data.
REQ-009 SHALL have port i_Rd_En, input, 1 bit: one-cycle read strobe qualifying i_Addr.
REQ-010 SHALL have port o_Rd_Data, output, 16 bits: registered read data.
REQ-011 SHALL have port o_Rd_Valid, output, 1 bit: high for one cycle when o_Rd_Data is valid.
REQ-012 SHALL have port o_UART_TX, output, 1 bit: serial line, idle high.
REQ-013 SHALL have port o_Overrun, output, 1 bit: sticky flag set when a DDR write is dropped.

Function
REQ-014 SHALL define ready as 1 when the character buffer can accept a byte; buffer depth is 1 without DISPLAY_FIFO_EN and 4 with it.
REQ-015 SHALL accept a DDR write (i_Wr_En=1, i_Addr=DDR_ADDR) only when ready=1 in that cycle, storing i_Wr_Data[7:0] and ignoring bits 15:8.
REQ-016 SHALL drop a DDR write made while ready=0 and set o_Overrun=1 on the next edge; o_Overrun stays set until reset.
REQ-017 SHALL ignore writes to DSR_ADDR and to all unmatched addresses.
REQ-018 SHALL, one cycle after i_Rd_En, drive o_Rd_Valid=1 and o_Rd_Data as follows: DSR_ADDR gives {ready,15'b0}; DDR_ADDR gives {8'b0, last accepted byte}; any other address gives 16'h0000.
REQ-019 SHALL implement the TX FSM states IDLE -> START -> DATA -> STOP -> IDLE.
REQ-020 SHALL, in IDLE with the buffer non-empty, pop the oldest byte into the shift register and enter START on the same edge.
REQ-021 SHALL hold each of START (line 0), the 8 DATA bits (LSB first), and STOP (line 1) for exactly CLKS_PER_BIT cycles, using a baud counter counting 0..CLKS_PER_BIT-1 and a 3-bit bit index.
REQ-022 SHALL return from STOP to IDLE; a pending byte starts its START on the following edge, so one IDLE cycle separates frames.
REQ-023 SHALL, on a write and a pop in the same cycle, decide acceptance from the pre-edge ready value; the pop frees space only from the next cycle.
REQ-024 SHALL, at depth 1, make ready rise the cycle after the holding register is popped into the shift register, not at end of frame.
REQ-025 SHALL keep byte order FIFO, with wrap-around of 2-bit read/write pointers and a 3-bit count (0..4); full means count==4.

Reset
REQ-026 SHALL, when i_Reset=1 at an edge, set: o_UART_TX=1, FSM=IDLE, counters=0, buffer empty, last byte=8'h00, o_Overrun=0, o_Rd_Valid=0, o_Rd_Data=16'h0000.
REQ-027 SHALL abort an in-progress frame on reset mid-frame, drive the line high from the next cycle, and discard all buffered bytes.
REQ-028 SHALL give i_Reset priority over simultaneous writes and reads.

Configuration
REQ-029 SHALL use macro DISPLAY_FIFO_EN: when defined, the buffer is a 4-entry FIFO; when undefined, the buffer is a single holding register with identical port behaviour.

Verification (bench CLKS_PER_BIT=4)
REQ-030 SHALL cover: reset, then read DSR -> o_Rd_Data=16'h8000 one cycle later with o_Rd_Valid=1; o_UART_TX=1.
REQ-031 SHALL cover: write DDR 16'h1241 -> frame 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles (40 cycles); DDR read returns 16'h0041.
REQ-032 SHALL cover, without FIFO: write 'A' then 'B' one cycle apart -> 'B' accepted only once ready=1; write during busy-full -> dropped, o_Overrun=1.
REQ-033 SHALL cover, with FIFO: 4 back-to-back writes 'A','B','C','D' all accepted, a 5th while count==4 dropped; serial output order A,B,C,D.
REQ-034 SHALL cover: reset asserted at cycle 10 of a frame -> o_UART_TX=1 next cycle, DSR reads 16'h8000, no residual frame.
REQ-035 SHALL cover: read of 16'hFE00 -> o_Rd_Data=16'h0000 with o_Rd_Valid=1.

Source files
------------

// File: rtl/lc3_display_uart.sv
// lc3_display_uart: LC3 memory-mapped display (DSR/DDR) driving an 8N1 UART transmitter.
// Define DISPLAY_FIFO_EN for a 4-entry character FIFO instead of a single holding register.
module lc3_display_uart #(
    parameter int          CLKS_PER_BIT = 217,
    parameter logic [15:0] DSR_ADDR     = 16'hFE04,
    parameter logic [15:0] DDR_ADDR     = 16'hFE06
) (
    input  logic        i_CLK,
    input  logic        i_Reset,
    input  logic [15:0] i_Addr,
    input  logic        i_Wr_En,
    input  logic [15:0] i_Wr_Data,
    input  logic        i_Rd_En,
    output logic [15:0] o_Rd_Data,
    output logic        o_Rd_Valid,
    output logic        o_UART_TX,
    output logic        o_Overrun
);
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q, last_q, pop_byte;
    logic [15:0]   rd_data_q;
    logic          tx_q, overrun_q, rd_valid_q, ready, empty, pop, wr_ddr, accept, baud_end, unused_hi;
    assign wr_ddr    = i_Wr_En && i_Addr == DDR_ADDR;
    assign accept    = wr_ddr && ready;
    assign pop       = state_q == IDLE && !empty;
    assign baud_end  = baud_q == BW'(CLKS_PER_BIT - 1);
    assign unused_hi = ^i_Wr_Data[15:8];
`ifdef DISPLAY_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] rd_ptr_q, wr_ptr_q;
    logic [2:0] count_q, count_d;
    assign ready    = count_q != 3'd4;
    assign empty    = count_q == 3'd0;
    assign pop_byte = mem_q[rd_ptr_q];
    assign count_d  = count_q + {2'b0, accept} - {2'b0, pop};
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= i_Wr_Data[7:0];
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_d;
        end
    end
`else
    logic [7:0] hold_q;
    logic       full_q;
    assign ready    = !full_q;
    assign empty    = !full_q;
    assign pop_byte = hold_q;
    // accept and pop are exclusive: pop needs a full register, accept needs an empty one
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else if (accept) begin
            hold_q <= i_Wr_Data[7:0];
            full_q <= 1'b1;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end
`endif
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    shift_q <= pop_byte;
                    baud_q  <= '0;
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: if (baud_end) begin
                    baud_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= shift_q[0];
                    state_q <= DATA;
                end else baud_q <= baud_q + BW'(1);
                DATA: if (baud_end) begin
                    baud_q <= '0;
                    if (bit_q == 3'd7) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                    end
                end else baud_q <= baud_q + BW'(1);
                STOP: if (baud_end) begin
                    baud_q  <= '0;
                    state_q <= IDLE;
                end else baud_q <= baud_q + BW'(1);
                default: state_q <= IDLE;
            endcase
        end
    end
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            last_q     <= '0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (accept) last_q <= i_Wr_Data[7:0];
            if (wr_ddr && !ready) overrun_q <= 1'b1;
            rd_valid_q <= i_Rd_En;
            rd_data_q  <= !i_Rd_En ? 16'h0000 :
                          i_Addr == DSR_ADDR ? {ready, 15'b0} :
                          i_Addr == DDR_ADDR ? {8'h00, last_q} : 16'h0000;
        end
    end
    assign o_Rd_Data  = rd_data_q;
    assign o_Rd_Valid = rd_valid_q;
    assign o_UART_TX  = tx_q;
    assign o_Overrun  = overrun_q;
endmodule

// File: tb/tb_lc3_display_uart.sv
// tb_lc3_display_uart: directed + random checks of lc3_display_uart against a queue-based model and a UART line decoder.
module tb_lc3_display_uart;
    localparam int N = 4;
    localparam logic [15:0] DSR = 16'hFE04;
    localparam logic [15:0] DDR = 16'hFE06;
`ifdef DISPLAY_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    logic clk = 0, rst = 1, wr = 0, rd = 0;
    logic [15:0] addr = 0, wdata = 0;
    logic [15:0] rd_data;
    logic rd_valid, tx, ovr;
    int checks = 0, errors = 0, cyc = 0, free_at = 0, rx_cnt = -1;
    logic [7:0] mq[$], exq[$], rxq[$];
    logic [7:0] m_last = 0, rx_byte = 0;
    logic m_ovr = 0;

    lc3_display_uart #(.CLKS_PER_BIT(N), .DSR_ADDR(DSR), .DDR_ADDR(DDR)) dut (
        .i_CLK(clk), .i_Reset(rst), .i_Addr(addr), .i_Wr_En(wr), .i_Wr_Data(wdata),
        .i_Rd_En(rd), .o_Rd_Data(rd_data), .o_Rd_Valid(rd_valid), .o_UART_TX(tx), .o_Overrun(ovr)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge: the model consumes the pre-edge inputs, then outputs are checked after the edge.
    task automatic step();
        logic acc, ddr, do_rd;
        logic [15:0] er;
        ddr = wr && addr == DDR;
        er = addr == DSR ? {mq.size() < DEPTH, 15'b0} : addr == DDR ? {8'h00, m_last} : 16'h0000;
        if (rst) begin
            mq.delete();
            free_at = 0;
            m_last = 0;
            m_ovr = 0;
        end else begin
            acc = ddr && mq.size() < DEPTH;
            if (ddr && !acc) m_ovr = 1;
            if (cyc >= free_at && mq.size() > 0) begin
                exq.push_back(mq.pop_front());
                free_at = cyc + 10 * N + 1;
            end
            if (acc) begin
                mq.push_back(wdata[7:0]);
                m_last = wdata[7:0];
            end
        end
        do_rd = rd && !rst;
        @(posedge clk);
        #1;
        cyc++;
        check("rd_valid", rd_valid, do_rd);
        if (do_rd) check("rd_data", rd_data, er);
        check("overrun", ovr, m_ovr);
    endtask

    task automatic drive(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
        wr = w;
        rd = r;
        addr = a;
        wdata = d;
        step();
    endtask

    task automatic drain_compare();
        for (int i = 0; i < 3000 && (mq.size() > 0 || cyc < free_at + 2 * N); i++) drive(0, 0, 0, 0);
        check("drain", mq.size(), 0);
        check("rx_count", rxq.size(), exq.size());
        for (int i = 0; i < exq.size() && i < rxq.size(); i++) check("rx_byte", rxq[i], exq[i]);
        exq.delete();
        rxq.delete();
    endtask

    // Serial decoder sampling mid-bit on the falling edge.
    always @(negedge clk) begin
        if (rst) rx_cnt = -1;
        else if (rx_cnt < 0) begin
            if (tx === 1'b0) rx_cnt = 0;
        end else rx_cnt++;
        if (!rst && rx_cnt >= 0 && rx_cnt % N == N / 2) begin
            if (rx_cnt / N == 0) check("start_bit", tx, 0);
            else if (rx_cnt / N < 9) rx_byte[rx_cnt / N - 1] = tx;
            else begin
                check("stop_bit", tx, 1);
                rxq.push_back(rx_byte);
                rx_cnt = -1;
            end
        end
    end

    initial begin
        logic [9:0] frame;
        int lows;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        rst = 0;
        check("reset_tx", tx, 1);
        check("reset_rd_data", rd_data, 0);
        drive(0, 1, DSR, 0);
        check("dsr_after_reset", rd_data, 16'h8000);
        check("tx_idle", tx, 1);
        frame = {1'b1, 8'h41, 1'b0};
        drive(1, 0, DDR, 16'h1241);
        wr = 0;
        for (int i = 0; i < 10 * N; i++) begin
            step();
            check("frame_bit", tx, frame[i / N]);
        end
        drive(0, 1, DDR, 0);
        check("ddr_read", rd_data, 16'h0041);
        drain_compare();
        drive(1, 0, DDR, 16'h0041);
        drive(1, 0, DDR, 16'h0042);
        for (int i = 0; i < 200 && mq.size() >= DEPTH; i++) drive(0, 1, DSR, 0);
        drive(1, 0, DDR, 16'h0042);
        drive(1, 0, DDR, 16'h0043);
        drain_compare();
        for (int i = 0; i < 6; i++) drive(1, 0, DDR, 16'h0041 + 16'(i));
        drain_compare();
        drive(1, 0, DDR, 16'h00A5);
        wr = 0;
        for (int i = 0; i < 10; i++) step();
        rst = 1;
        step();
        rst = 0;
        check("tx_after_abort", tx, 1);
        exq.delete();
        rxq.delete();
        drive(0, 1, DSR, 0);
        check("dsr_after_abort", rd_data, 16'h8000);
        lows = 0;
        for (int i = 0; i < 12 * N; i++) begin
            drive(0, 0, 0, 0);
            if (tx !== 1'b1) lows++;
        end
        check("no_residual", lows, 0);
        check("no_rx_after_abort", rxq.size(), 0);
        drive(0, 1, 16'hFE00, 0);
        check("unmapped_read", rd_data, 16'h0000);
        for (int i = 0; i < 600; i++) begin
            int sel;
            logic [15:0] a;
            sel = $urandom_range(0, 3);
            a = sel == 0 ? DSR : sel == 3 ? 16'($urandom) : DDR;
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, a, 16'($urandom));
        end
        drain_compare();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
